regfile_rename: RTL and testbench

Architectural register file with per-register rename tags for the out-of-order core. Sits between the decoder/dispatch stage and the reorder buffer's commit port. The decoder reads source operands as either a committed value or the ROB tag that will produce it, and writes the destination tag at dispatch. The ROB writes committed results back in program order, and its `flush` clears all outstanding renames.

---
 rtl/regfile_rename.sv | 64 ++++++
 tb/tb_regfile_rename.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register ROB rename tags and commit bypass
module regfile_rename #(
    parameter int NUM_REGS  = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 rename_valid,
    input  logic [4:0]           rename_rd,
    input  logic [TAG_WIDTH-1:0] rename_tag,
    input  logic                 load_val,
    input  logic [4:0]           val_rd,
    input  logic [TAG_WIDTH-1:0] tag,
    input  logic [31:0]          val,
    input  logic [4:0]           rs1_idx,
    input  logic [4:0]           rs2_idx,
    output logic [31:0]          rs1_val,
    output logic [31:0]          rs2_val,
    output logic [TAG_WIDTH-1:0] rs1_tag,
    output logic [TAG_WIDTH-1:0] rs2_tag
);
    logic [31:0]          regs [NUM_REGS];
    logic [TAG_WIDTH-1:0] tags [NUM_REGS];
    logic [TAG_WIDTH-1:0] t1, t2;
    logic                 byp1, byp2;

    // x0 is constant zero in both value and tag
    always_ff @(posedge clk) begin
        regs[0] <= '0;
        tags[0] <= '0;
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        // commit writes the value; flush beats rename, rename beats a matching-tag clear
        always_ff @(posedge clk) begin
            if (rst) begin
                regs[r] <= '0;
                tags[r] <= '0;
            end else begin
                if (load_val && val_rd == 5'(r))
                    regs[r] <= val;
                if (flush)
                    tags[r] <= '0;
                else if (rename_valid && rename_rd == 5'(r))
                    tags[r] <= rename_tag;
                else if (load_val && val_rd == 5'(r) && tags[r] == tag)
                    tags[r] <= '0;
            end
        end
    end

    // source reads: state, or the committing value when it resolves the pending tag
    always_comb begin
        t1      = tags[rs1_idx];
        t2      = tags[rs2_idx];
        byp1    = t1 != '0 && load_val && val_rd == rs1_idx && tag == t1;
        byp2    = t2 != '0 && load_val && val_rd == rs2_idx && tag == t2;
        rs1_val = rs1_idx == '0 ? '0 : byp1 ? val : regs[rs1_idx];
        rs2_val = rs2_idx == '0 ? '0 : byp2 ? val : regs[rs2_idx];
        rs1_tag = (rs1_idx == '0 || byp1) ? '0 : t1;
        rs2_tag = (rs2_idx == '0 || byp2) ? '0 : t2;
    end
endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: directed and randomized checks against an array-based reference model
module tb_regfile_rename;
    logic        clk = 0;
    logic        rst, flush, rename_valid, load_val;
    logic [4:0]  rename_rd, val_rd, rs1_idx, rs2_idx;
    logic [3:0]  rename_tag, tag;
    logic [31:0] val, rs1_val, rs2_val;
    logic [3:0]  rs1_tag, rs2_tag;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_regs [32];
    logic [3:0]  m_tags [32];

    always #5 clk = ~clk;

    regfile_rename #(.NUM_REGS(32), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rename_valid(rename_valid), .rename_rd(rename_rd), .rename_tag(rename_tag),
        .load_val(load_val), .val_rd(val_rd), .tag(tag), .val(val),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_read(input logic [4:0] idx, output logic [31:0] v, output logic [3:0] t);
        v = m_regs[idx];
        t = m_tags[idx];
        if (idx == 0) begin
            v = 0;
            t = 0;
        end else if (t != 0 && load_val && val_rd == idx && tag == t) begin
            v = val;
            t = 0;
        end
    endtask

    task automatic clear();
        {rst, flush, rename_valid, load_val} = '0;
        {rename_rd, val_rd, rename_tag, tag, val} = '0;
    endtask

    task automatic compare();
        logic [31:0] v;
        logic [3:0]  t;
        model_read(rs1_idx, v, t);
        check("rs1_val", rs1_val, v);
        check("rs1_tag", 32'(rs1_tag), 32'(t));
        model_read(rs2_idx, v, t);
        check("rs2_val", rs2_val, v);
        check("rs2_tag", 32'(rs2_tag), 32'(t));
    endtask

    task automatic tick();
        #3 compare();
        @(posedge clk);
        if (rst) begin
            foreach (m_regs[i]) begin
                m_regs[i] = 0;
                m_tags[i] = 0;
            end
        end else begin
            if (load_val && val_rd != 0) begin
                m_regs[val_rd] = val;
                if (m_tags[val_rd] == tag) m_tags[val_rd] = 0;
            end
            if (flush) foreach (m_tags[i]) m_tags[i] = 0;
            else if (rename_valid && rename_rd != 0) m_tags[rename_rd] = rename_tag;
        end
        #1;
    endtask

    task automatic expect_reg(input logic [4:0] idx, input logic [31:0] v, input logic [3:0] t);
        rs1_idx = idx;
        rs2_idx = idx;
        #1;
        check($sformatf("x%0d_val", idx), rs1_val, v);
        check($sformatf("x%0d_tag", idx), 32'(rs1_tag), 32'(t));
        check($sformatf("x%0d_val2", idx), rs2_val, v);
        check($sformatf("x%0d_tag2", idx), 32'(rs2_tag), 32'(t));
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] t);
        rename_valid = 1;
        rename_rd = rd;
        rename_tag = t;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] v);
        load_val = 1;
        val_rd = rd;
        tag = t;
        val = v;
    endtask

    initial begin
        clear();
        rs1_idx = 0;
        rs2_idx = 0;
        foreach (m_regs[i]) begin
            m_regs[i] = 0;
            m_tags[i] = 0;
        end
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 32; i++) begin
            expect_reg(5'(i), 0, 0);
            tick();
        end

        rename(0, 3); tick(); clear();
        commit(0, 3, 32'hFFFF_FFFF); tick(); clear();
        expect_reg(0, 0, 0);

        rename(5, 2); tick(); clear();
        expect_reg(5, 0, 2);
        commit(5, 2, 32'h1234);
        expect_reg(5, 32'h1234, 0);
        tick(); clear();
        expect_reg(5, 32'h1234, 0);

        rename(7, 1); tick();
        rename(7, 4); tick(); clear();
        commit(7, 1, 32'hAA); tick(); clear();
        expect_reg(7, 32'hAA, 4);
        commit(7, 4, 32'hBB); tick(); clear();
        expect_reg(7, 32'hBB, 0);

        rename(9, 3); tick(); clear();
        commit(9, 3, 32'h55);
        rename(9, 6);
        expect_reg(9, 32'h55, 0);
        tick(); clear();
        expect_reg(9, 32'h55, 6);

        rename(1, 2); tick();
        rename(2, 3); tick(); clear();
        flush = 1;
        commit(1, 2, 32'h40);
        rename(3, 5);
        tick(); clear();
        expect_reg(1, 32'h40, 0);
        expect_reg(2, 0, 0);
        expect_reg(3, 0, 0);

        rename(4, 7); tick(); clear();
        expect_reg(4, 0, 7);
        rst = 1;
        rename(4, 5);
        commit(6, 0, 32'h77);
        tick(); clear();
        expect_reg(4, 0, 0);
        expect_reg(6, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            flush        = ($urandom_range(0, 29) == 0);
            rename_valid = $urandom_range(0, 1);
            rename_rd    = 5'($urandom_range(0, 31));
            rename_tag   = 4'($urandom_range(1, 15));
            load_val     = $urandom_range(0, 1);
            val_rd       = 5'($urandom_range(0, 31));
            tag          = $urandom_range(0, 2) != 0 ? m_tags[val_rd] : 4'($urandom_range(0, 15));
            val          = $urandom;
            rs1_idx      = $urandom_range(0, 1) ? val_rd : 5'($urandom_range(0, 31));
            rs2_idx      = 5'($urandom_range(0, 31));
            tick();
        end
        clear();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
